mem_dma: RTL and testbench

- Memory-port initiator: block copy/fill engine driving the on-chip synchronous single-port RAM's addr/data-in/we port and consuming its data-out.
- Performs Z80 LDIR-style forward copies and constant fills on behalf of the CPU/loader, then hands the RAM port back via `busy`.
- Sits between the control logic (command side) and the RAM's port mux.

---
 rtl/mem_dma_pkg.sv | 18 +
 rtl/mem_dma_ptr.sv | 33 +++
 rtl/mem_dma.sv | 150 +++++++++++++++
 tb/tb_mem_dma.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dma_pkg.sv
// mem_dma shared types: FSM encoding, mode constants, default widths.
// Optional reverse (LDDR) stepping is enabled by MEM_DMA_REVERSE_EN.
package mem_dma_pkg;

   localparam int ADDR_W_DEF = 10;
   localparam int DATA_W_DEF = 8;

   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/mem_dma_ptr.sv
// Loadable wrapping address pointer with step enable.
// Direction input exists only when MEM_DMA_REVERSE_EN is defined.
module mem_dma_ptr #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         step,
`ifdef MEM_DMA_REVERSE_EN
   input  logic         dir,
`endif
   output logic [W-1:0] ptr
);

   localparam logic [W-1:0] ONE = W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (load) begin
         ptr <= load_val;
      end else if (step) begin
`ifdef MEM_DMA_REVERSE_EN
         ptr <= dir ? (ptr - ONE) : (ptr + ONE);
`else
         ptr <= ptr + ONE;
`endif
      end
   end

endmodule

// File: rtl/mem_dma.sv
// Block copy/fill engine owning the RAM port while busy.
// MEM_DMA_REVERSE_EN adds a dir input for decrementing (LDDR) transfers.
module mem_dma
   import mem_dma_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = ADDR_W + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mode,
`ifdef MEM_DMA_REVERSE_EN
   input  logic              dir,
`endif
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dst,
   input  logic [LEN_W-1:0]  len,
   input  logic [DATA_W-1:0] fill_val,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_t              state_q;
   state_t              state_d;
   logic [LEN_W-1:0]    rem_q;
   logic                mode_q;
   logic [DATA_W-1:0]   fill_q;
   logic [ADDR_W-1:0]   src_ptr;
   logic [ADDR_W-1:0]   dst_ptr;
   logic                take;
   logic                step;
   logic                last;

   assign take = (state_q == IDLE) && start && (len != '0);
   assign step = (state_q == WR);
   assign last = (rem_q == LEN_W'(1));

`ifdef MEM_DMA_REVERSE_EN
   logic dir_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir_q <= 1'b0;
      end else if (take) begin
         dir_q <= dir;
      end
   end
`endif

   mem_dma_ptr #(.W(ADDR_W)) u_src_ptr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (take),
      .load_val (src),
      .step     (step),
`ifdef MEM_DMA_REVERSE_EN
      .dir      (dir_q),
`endif
      .ptr      (src_ptr)
   );

   mem_dma_ptr #(.W(ADDR_W)) u_dst_ptr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (take),
      .load_val (dst),
      .step     (step),
`ifdef MEM_DMA_REVERSE_EN
      .dir      (dir_q),
`endif
      .ptr      (dst_ptr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rem_q   <= '0;
         mode_q  <= MODE_COPY;
         fill_q  <= '0;
      end else begin
         state_q <= state_d;
         if (take) begin
            rem_q  <= len;
            mode_q <= mode;
            fill_q <= fill_val;
         end else if (step) begin
            rem_q  <= rem_q - LEN_W'(1);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (len == '0) begin
                  state_d = DONE;
               end else if (mode == MODE_FILL) begin
                  state_d = WR;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD:   state_d = WR;
         WR: begin
            if (last) begin
               state_d = DONE;
            end else if (mode_q == MODE_FILL) begin
               state_d = WR;
            end else begin
               state_d = RD;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // rdata feeds wdata combinationally: the read issued in RD lands in WR
   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      unique case (state_q)
         RD: begin
            busy     = 1'b1;
            mem_addr = src_ptr;
         end
         WR: begin
            busy      = 1'b1;
            mem_addr  = dst_ptr;
            mem_we    = 1'b1;
            mem_wdata = (mode_q == MODE_FILL) ? fill_q : mem_rdata;
         end
         DONE: done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_dma.sv
// Self-checking bench for mem_dma: vector table plus write scoreboard.
// Reverse vector is compiled only with MEM_DMA_REVERSE_EN.
module tb_mem_dma;
   import mem_dma_pkg::*;

   typedef struct {
      string      name;
      logic       mode;
      logic       dir;
      logic [9:0] src;
      logic [9:0] dst;
      logic [10:0] len;
      logic [7:0] fv;
      int         poke;
      int         exp_done;
   } vec_t;

   typedef struct {
      logic [9:0] addr;
      logic [7:0] data;
   } wr_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        mode;
`ifdef MEM_DMA_REVERSE_EN
   logic        dir;
`endif
   logic [9:0]  src;
   logic [9:0]  dst;
   logic [10:0] len;
   logic [7:0]  fill_val;
   logic        busy;
   logic        done;
   logic [9:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic [7:0]  mem_rdata;

   logic [7:0]  ram [1024];
   logic [7:0]  ref_mem [1024];
   logic        ld_en;
   logic [9:0]  ld_a;
   logic [7:0]  ld_d;

   wr_t         exp_q[$];
   vec_t        vecs[$];
   int          nchk;
   int          nbad;

   mem_dma dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .mode      (mode),
`ifdef MEM_DMA_REVERSE_EN
      .dir       (dir),
`endif
      .src       (src),
      .dst       (dst),
      .len       (len),
      .fill_val  (fill_val),
      .busy      (busy),
      .done      (done),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ld_en) begin
         ram[ld_a] <= ld_d;
      end else if (mem_we) begin
         ram[mem_addr] <= mem_wdata;
      end
      mem_rdata <= ram[mem_addr];
   end

   always @(negedge clk) begin
      if (rst_n && mem_we) begin
         nchk++;
         if (exp_q.size() == 0) begin
            nbad++;
            $display("FAIL write_unexpected addr=%h data=%h", mem_addr, mem_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (mem_addr !== e.addr || mem_wdata !== e.data) begin
               nbad++;
               $display("FAIL write got=%h:%h exp=%h:%h",
                        mem_addr, mem_wdata, e.addr, e.data);
            end
         end
      end
   end

   task automatic check(input string nm, input int got, input int exp);
      nchk++;
      if (got != exp) begin
         nbad++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
      end
   endtask

   task automatic check_image(input string nm);
      int diffs;
      diffs = 0;
      for (int i = 0; i < 1024; i++) begin
         if (ram[i] !== ref_mem[i]) diffs++;
      end
      check({nm, "_image_diffs"}, diffs, 0);
   endtask

   task automatic model(input vec_t v);
      logic [9:0] s;
      logic [9:0] d;
      logic [7:0] b;
      s = v.src;
      d = v.dst;
      for (int i = 0; i < int'(v.len); i++) begin
         b = v.mode ? v.fv : ref_mem[s];
         ref_mem[d] = b;
         exp_q.push_back('{d, b});
         if (v.dir) begin
            s = s - 10'd1;
            d = d - 10'd1;
         end else begin
            s = s + 10'd1;
            d = d + 10'd1;
         end
      end
   endtask

   task automatic run_vec(input vec_t v);
      int dcyc;
      int busy_bad;
      int idle_bad;
      model(v);
      @(negedge clk);
      mode     = v.mode;
`ifdef MEM_DMA_REVERSE_EN
      dir      = v.dir;
`endif
      src      = v.src;
      dst      = v.dst;
      len      = v.len;
      fill_val = v.fv;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      dcyc = 0;
      busy_bad = 0;
      for (int c = 1; c <= 1100; c++) begin
         @(negedge clk);
         if (c == v.poke) begin
            start    = 1'b1;
            mode     = MODE_FILL;
            dst      = 10'h000;
            len      = 11'd5;
            fill_val = 8'hEE;
         end else begin
            start    = 1'b0;
         end
         if (done) begin
            dcyc = c;
            if (busy) busy_bad++;
            break;
         end
         if (busy !== (v.len != 0)) busy_bad++;
      end
      start = 1'b0;
      check({v.name, "_done_cycle"}, dcyc, v.exp_done);
      check({v.name, "_busy"}, busy_bad, 0);
      idle_bad = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (done || busy || mem_we || mem_addr != 0 || mem_wdata != 0)
            idle_bad++;
      end
      check({v.name, "_idle_after"}, idle_bad, 0);
      check({v.name, "_pending_writes"}, exp_q.size(), 0);
      check_image(v.name);
   endtask

   initial begin
      nchk     = 0;
      nbad     = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      mode     = MODE_COPY;
`ifdef MEM_DMA_REVERSE_EN
      dir      = 1'b0;
`endif
      src      = '0;
      dst      = '0;
      len      = '0;
      fill_val = '0;
      ld_en    = 1'b0;
      ld_a     = '0;
      ld_d     = '0;

      for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i) ^ 8'h3C;
      ref_mem[10'h010] = 8'h11;
      ref_mem[10'h011] = 8'h22;
      ref_mem[10'h012] = 8'h33;
      ref_mem[10'h013] = 8'h44;
      ref_mem[10'h100] = 8'h7E;

      #2;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_we", int'(mem_we), 0);
      check("rst_addr", int'(mem_addr), 0);
      check("rst_wdata", int'(mem_wdata), 0);

      for (int i = 0; i < 1024; i++) begin
         @(negedge clk);
         ld_en = 1'b1;
         ld_a  = 10'(i);
         ld_d  = ref_mem[i];
      end
      @(negedge clk);
      ld_en = 1'b0;
      rst_n = 1'b1;
      check_image("preload");

      vecs.push_back('{"copy", MODE_COPY, 1'b0, 10'h010, 10'h200,
                       11'd4, 8'h00, 0, 9});
      vecs.push_back('{"fill_wrap", MODE_FILL, 1'b0, 10'h000, 10'h3FE,
                       11'd4, 8'hA5, 0, 5});
      vecs.push_back('{"zero_len", MODE_COPY, 1'b0, 10'h010, 10'h300,
                       11'd0, 8'h00, 0, 1});
      vecs.push_back('{"overlap", MODE_COPY, 1'b0, 10'h100, 10'h101,
                       11'd3, 8'h00, 3, 7});
`ifdef MEM_DMA_REVERSE_EN
      vecs.push_back('{"reverse", MODE_COPY, 1'b1, 10'h013, 10'h283,
                       11'd4, 8'h00, 0, 9});
`endif
      vecs.push_back('{"full_fill", MODE_FILL, 1'b0, 10'h000, 10'h155,
                       11'd1024, 8'hC3, 0, 1025});

      foreach (vecs[i]) run_vec(vecs[i]);

      // reset mid-fill: writes committed at edges 1..5 only
      for (int i = 0; i < 5; i++) begin
         ref_mem[i] = 8'h55;
         exp_q.push_back('{10'(i), 8'h55});
      end
      @(negedge clk);
      mode     = MODE_FILL;
      dst      = 10'h000;
      len      = 11'd16;
      fill_val = 8'h55;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("pre_rst_we", int'(mem_we), 1);
      rst_n = 1'b0;
      #1;
      check("async_rst_we", int'(mem_we), 0);
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_addr", int'(mem_addr), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_fill_pending", exp_q.size(), 0);
      check("rst_fill_done", int'(done), 0);
      check_image("rst_fill");

      $display("test done: total=%0d bad=%0d", nchk, nbad);
      $finish;
   end

endmodule
